// File: rtl/dispatch_pkg.sv
// Shared types and decoder constants for the dispatch router slice.
// Payload layout is MSB-first: {rs1, rs2, rd, alu_op, opcode, func3, func7}.
package dispatch_pkg;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [2:0] alu_op;
    logic [6:0] opcode;
    logic [2:0] func3;
    logic [6:0] func7;
  } uop_t;

  typedef enum logic [1:0] {
    FU_ALU = 2'd0,
    FU_MEM = 2'd1,
    FU_BR  = 2'd2
  } fu_e;

  typedef struct packed {
    fu_e  fu;
    uop_t uop;
  } entry_t;

  localparam int UOP_W = $bits(uop_t);

  localparam logic [2:0] ALUOP_MEM   = 3'b000;
  localparam logic [2:0] ALUOP_BR    = 3'b001;
  localparam logic [2:0] ALUOP_RTYPE = 3'b010;
  localparam logic [2:0] ALUOP_ITYPE = 3'b011;
  localparam logic [2:0] ALUOP_LUI   = 3'b100;
  localparam logic [2:0] ALUOP_JALR  = 3'b110;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // Only meaningful for a legal (one-hot) select; anything else maps to ALU.
  function automatic fu_e fu_encode(input logic alu, input logic mem, input logic br);
    if (mem)     return FU_MEM;
    else if (br) return FU_BR;
    else         return FU_ALU;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// In-order synchronous FIFO with extra-MSB pointers and a one-edge flush.
// Read data is forced to zero while empty so consumers never see stale entries.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + PTR_ONE;
      if (pop  && !empty) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage carries no reset; validity is tracked purely by the pointers.
  always_ff @(posedge clk) begin
    if (push && !full && !reset && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/dispatch_router.sv
// Buffers decoded micro-ops and issues the head entry to exactly one of the
// ALU / memory / branch ports; words without a unique FU are dropped and counted.
module dispatch_router
  import dispatch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [4:0]       rd,
  input  logic [2:0]       alu_op,
  input  logic [6:0]       opcode,
  input  logic [2:0]       func3,
  input  logic [6:0]       func7,
  input  logic             fu_alu,
  input  logic             fu_mem,
  input  logic             fu_br,
  output logic [UOP_W-1:0] out_uop,
  output logic             alu_valid,
  input  logic             alu_ready,
  output logic             mem_valid,
  input  logic             mem_ready,
  output logic             br_valid,
  input  logic             br_ready,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  entry_t wr_entry;
  entry_t head;
  logic   full;
  logic   empty;
  logic   legal;
  logic   accept;
  logic   push;
  logic   pop;

  assign legal    = $onehot({fu_alu, fu_mem, fu_br});
  assign in_ready = !full && !reset;
  assign accept   = in_valid && in_ready;
  assign push     = accept && legal && !flush;

  always_comb begin
    wr_entry            = '0;
    wr_entry.fu         = fu_encode(fu_alu, fu_mem, fu_br);
    wr_entry.uop.rs1    = rs1;
    wr_entry.uop.rs2    = rs2;
    wr_entry.uop.rd     = rd;
    wr_entry.uop.alu_op = alu_op;
    wr_entry.uop.opcode = opcode;
    wr_entry.uop.func3  = func3;
    wr_entry.uop.func7  = func7;
  end

  // Issue decisions depend only on registered FIFO state, never on in_* inputs.
  assign alu_valid = !empty && (head.fu == FU_ALU);
  assign mem_valid = !empty && (head.fu == FU_MEM);
  assign br_valid  = !empty && (head.fu == FU_BR);
  assign out_uop   = head.uop;
  assign pop       = (alu_valid && alu_ready) || (mem_valid && mem_ready) ||
                     (br_valid && br_ready);

  sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (push),
    .wdata (wr_entry),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_cnt <= '0;
    end else if (!flush && accept && !legal && (illegal_cnt != '1)) begin
      illegal_cnt <= illegal_cnt + CNT_ONE;
    end
  end

endmodule
